// File: rtl/iso7816_3_t0_tpdu_master.sv
// Terminal-side ISO7816-3 T=0 TPDU engine: sends the 5-byte header, follows procedure bytes,
// moves command/response data between host and card, and returns SW1/SW2 with an error code.
module iso7816_3_t0_tpdu_master #(
  parameter int WT_WIDTH = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmdStart,
  input  logic [39:0]         cmdHeader,
  input  logic                cmdIsWrite,
  input  logic [WT_WIDTH-1:0] wtCycles,
  output logic [7:0]          txData,
  output logic                txValid,
  input  logic                txReady,
  input  logic [7:0]          rxData,
  input  logic                rxValid,
  input  logic                rxError,
  input  logic [7:0]          hostData,
  input  logic                hostValid,
  output logic                hostReady,
  output logic [7:0]          cardData,
  output logic                cardValid,
  output logic                busy,
  output logic                done,
  output logic [15:0]         sw,
  output logic [2:0]          errCode
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX_HDR, S_WAIT_PB, S_TX_DATA, S_RX_DATA, S_WAIT_SW2, S_ERROR, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ERR_OK = 3'd0, ERR_TIMEOUT = 3'd1, ERR_BAD_PB = 3'd2, ERR_RX = 3'd3, ERR_NO_DATA = 3'd4
  } err_t;

  state_t              r_state;
  logic [39:0]         r_hdr;
  logic                r_is_write;
  logic [2:0]          r_hdr_idx;
  logic [8:0]          r_rem;
  logic                r_xfer_all;
  logic [WT_WIDTH-1:0] r_wt;
  err_t                r_err_pend;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic                r_host_ready;
  logic [7:0]          r_card_data;
  logic                r_card_valid;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         r_sw;
  logic [2:0]          r_err_code;

  logic [7:0]          w_ins;
  logic [8:0]          w_rem_dec;
  logic [WT_WIDTH:0]   w_wt_inc;
  logic                w_wt_expired;
  logic                w_rx_state;
  logic                w_more;

  assign w_ins        = r_hdr[31:24];
  assign w_rem_dec    = (r_rem != 9'd0) ? r_rem - 9'd1 : r_rem;
  assign w_wt_inc     = {1'b0, r_wt} + {{WT_WIDTH{1'b0}}, 1'b1};
  assign w_wt_expired = w_wt_inc >= {1'b0, wtCycles};
  assign w_rx_state   = (r_state == S_WAIT_PB) || (r_state == S_RX_DATA) || (r_state == S_WAIT_SW2);
  assign w_more       = r_xfer_all && (w_rem_dec != 9'd0);

  function automatic logic [7:0] hdr_byte(input logic [39:0] hdr, input logic [2:0] idx);
    case (idx)
      3'd0:    hdr_byte = hdr[39:32];
      3'd1:    hdr_byte = hdr[31:24];
      3'd2:    hdr_byte = hdr[23:16];
      3'd3:    hdr_byte = hdr[15:8];
      3'd4:    hdr_byte = hdr[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_hdr        <= '0;
      r_is_write   <= 1'b0;
      r_hdr_idx    <= '0;
      r_rem        <= '0;
      r_xfer_all   <= 1'b0;
      r_wt         <= '0;
      r_err_pend   <= ERR_OK;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_host_ready <= 1'b0;
      r_card_data  <= '0;
      r_card_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sw         <= '0;
      r_err_code   <= '0;
    end else begin
      // NOTE: strobes default low here with non-blocking assignments; a branch below that raises
      // one overrides this default, so each pulse lasts exactly one cycle without extra logic.
      r_host_ready <= 1'b0;
      r_card_valid <= 1'b0;
      r_done       <= 1'b0;

      if (w_rx_state && rxError) begin
        r_err_pend <= ERR_RX;
        r_state    <= S_ERROR;
      end else if (w_rx_state && !rxValid && w_wt_expired) begin
        r_err_pend <= ERR_TIMEOUT;
        r_state    <= S_ERROR;
      end else begin
        if (w_rx_state) r_wt <= rxValid ? '0 : w_wt_inc[WT_WIDTH-1:0];
        case (r_state)
          S_IDLE: if (cmdStart) begin
            r_hdr      <= cmdHeader;
            r_is_write <= cmdIsWrite;
            r_hdr_idx  <= '0;
            r_err_code <= ERR_OK;
            r_sw       <= '0;
            r_tx_data  <= cmdHeader[39:32];
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            // Read with P3=0 asks for the full 256-byte response.
            r_rem      <= (!cmdIsWrite && cmdHeader[7:0] == 8'h00) ? 9'd256 : {1'b0, cmdHeader[7:0]};
            r_state    <= S_TX_HDR;
          end
          S_TX_HDR: if (txReady) begin
            if (r_hdr_idx == 3'd4) begin
              r_tx_valid <= 1'b0;
              r_wt       <= '0;
              r_state    <= S_WAIT_PB;
            end else begin
              r_hdr_idx <= r_hdr_idx + 3'd1;
              r_tx_data <= hdr_byte(r_hdr, r_hdr_idx + 3'd1);
            end
          end
          S_WAIT_PB: if (rxValid) begin
            if (rxData == 8'h60) begin
              r_state <= S_WAIT_PB;
            end else if (rxData[7:4] == 4'h6 || rxData[7:4] == 4'h9) begin
              r_sw[15:8] <= rxData;
              r_state    <= S_WAIT_SW2;
            end else if (rxData == w_ins || rxData == ~w_ins) begin
              if (r_rem == 9'd0) begin
                r_err_pend <= ERR_NO_DATA;
                r_state    <= S_ERROR;
              end else begin
                r_xfer_all <= (rxData == w_ins);
                r_state    <= r_is_write ? S_TX_DATA : S_RX_DATA;
              end
            end else begin
              r_err_pend <= ERR_BAD_PB;
              r_state    <= S_ERROR;
            end
          end
          S_TX_DATA: begin
            if (!r_tx_valid) begin
              if (hostValid) begin
                r_tx_data    <= hostData;
                r_tx_valid   <= 1'b1;
                r_host_ready <= 1'b1;
              end
            end else if (txReady) begin
              r_tx_valid <= 1'b0;
              r_rem      <= w_rem_dec;
              if (!w_more) begin
                r_wt    <= '0;
                r_state <= S_WAIT_PB;
              end
            end
          end
          S_RX_DATA: if (rxValid) begin
            r_card_data  <= rxData;
            r_card_valid <= 1'b1;
            r_rem        <= w_rem_dec;
            if (!w_more) r_state <= S_WAIT_PB;
          end
          S_WAIT_SW2: if (rxValid) begin
            r_sw[7:0] <= rxData;
            r_state   <= S_DONE;
          end
          S_ERROR: begin
            r_err_code <= r_err_pend;
            r_state    <= S_DONE;
          end
          S_DONE: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign txData    = r_tx_data;
  assign txValid   = r_tx_valid;
  assign hostReady = r_host_ready;
  assign cardData  = r_card_data;
  assign cardValid = r_card_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sw        = r_sw;
  assign errCode   = r_err_code;

endmodule

// File: tb/tb_iso7816_3_t0_tpdu_master.sv
// Directed bench for the T=0 TPDU master: plays the card and host by hand, checks every
// outcome against hand-computed values with immediate assertions.
module tb_iso7816_3_t0_tpdu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmdStart;
  logic [39:0] cmdHeader;
  logic        cmdIsWrite;
  logic [23:0] wtCycles;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxError;
  logic [7:0]  hostData;
  logic        hostValid;
  logic        hostReady;
  logic [7:0]  cardData;
  logic        cardValid;
  logic        busy;
  logic        done;
  logic [15:0] sw;
  logic [2:0]  errCode;

  iso7816_3_t0_tpdu_master #(.WT_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .cmdStart(cmdStart), .cmdHeader(cmdHeader),
    .cmdIsWrite(cmdIsWrite), .wtCycles(wtCycles), .txData(txData), .txValid(txValid),
    .txReady(txReady), .rxData(rxData), .rxValid(rxValid), .rxError(rxError),
    .hostData(hostData), .hostValid(hostValid), .hostReady(hostReady), .cardData(cardData),
    .cardValid(cardValid), .busy(busy), .done(done), .sw(sw), .errCode(errCode)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_q[$];
  logic [7:0] card_q[$];
  int         done_cnt = 0;
  int         hr_cnt = 0;

  always @(negedge clk) begin
    if (txValid && txReady) tx_q.push_back(txData);
    if (cardValid) card_q.push_back(cardData);
    if (done) done_cnt++;
    if (hostReady) hr_cnt++;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [39:0] hdr, input logic wr);
    cmdHeader  = hdr;
    cmdIsWrite = wr;
    cmdStart   = 1'b1;
    tick();
    cmdStart   = 1'b0;
  endtask

  task automatic wait_hdr(input string tag, input logic [39:0] hdr, input int base);
    for (int i = 0; i < 60 && !(tx_q.size() == base + 5 && !txValid); i++) tick();
    check({tag, "_hdr_len"}, tx_q.size() - base, 5);
    for (int i = 0; i < 5 && base + i < tx_q.size(); i++)
      check({tag, "_hdr_byte"}, tx_q[base + i], hdr[39 - 8 * i -: 8]);
  endtask

  task automatic rx(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
    rxData  = 8'h00;
    tick();
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
  endtask

  task automatic host_byte(input logic [7:0] b);
    hostData  = b;
    hostValid = 1'b1;
    for (int i = 0; i < 20 && !hostReady; i++) tick();
    hostValid = 1'b0;
    for (int i = 0; i < 20 && txValid; i++) tick();
  endtask

  initial begin
    int tb, cb, d0, h0, n;
    logic [39:0] hdr;
    reset = 1'b1; cmdStart = 1'b0; cmdHeader = '0; cmdIsWrite = 1'b0; wtCycles = 24'd1000;
    txReady = 1'b1; rxData = '0; rxValid = 1'b0; rxError = 1'b0; hostData = '0; hostValid = 1'b0;
    repeat (3) tick();
    check("rst_txValid", txValid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {hostReady, cardValid}, 0);
    check("rst_data", {txData, cardData}, 0);
    check("rst_sw", sw, 0);
    check("rst_err", errCode, 0);
    reset = 1'b0;
    tick();

    // Case 2 read: ACK then four data bytes, SW 90 00.
    hdr = 40'h00_B0_00_00_04; tb = tx_q.size(); cb = card_q.size(); d0 = done_cnt;
    start(hdr, 1'b0);
    check("c2_txValid_lat", txValid, 1);
    check("c2_busy", busy, 1);
    wait_hdr("c2", hdr, tb);
    rx(8'hB0); rx(8'h11); rx(8'h22); rx(8'h33); rx(8'h44); rx(8'h90); rx(8'h00);
    wait_done(d0);
    check("c2_done", done_cnt - d0, 1);
    check("c2_sw", sw, 16'h9000);
    check("c2_err", errCode, 0);
    check("c2_ncard", card_q.size() - cb, 4);
    if (card_q.size() - cb == 4) begin
      check("c2_card0", card_q[cb], 8'h11);
      check("c2_card3", card_q[cb + 3], 8'h44);
    end
    tick();
    check("c2_idle", busy, 0);

    // Case 3 write: three NACKs, each moving one host byte.
    hdr = 40'h00_D6_00_00_03; tb = tx_q.size(); d0 = done_cnt; h0 = hr_cnt;
    start(hdr, 1'b1);
    wait_hdr("c3", hdr, tb);
    for (int i = 0; i < 3; i++) begin
      rx(8'h29);
      host_byte(8'hA0 + 8'(i));
    end
    check("c3_ntx", tx_q.size() - tb, 8);
    if (tx_q.size() - tb == 8) begin
      check("c3_tx0", tx_q[tb + 5], 8'hA0);
      check("c3_tx2", tx_q[tb + 7], 8'hA2);
    end
    check("c3_hostReady", hr_cnt - h0, 3);
    rx(8'h90); rx(8'h00);
    wait_done(d0);
    check("c3_done", done_cnt - d0, 1);
    check("c3_sw", sw, 16'h9000);

    // NULL bytes, header held back by txReady first.
    hdr = 40'h80_A4_04_00_02; tb = tx_q.size(); cb = card_q.size(); d0 = done_cnt;
    txReady = 1'b0;
    start(hdr, 1'b0);
    tick(); tick();
    check("stall_txValid", txValid, 1);
    check("stall_txData", txData, 8'h80);
    txReady = 1'b1;
    wait_hdr("nul", hdr, tb);
    rx(8'h60); rx(8'h60); rx(8'h6A); rx(8'h82);
    wait_done(d0);
    repeat (4) tick();
    check("nul_done_once", done_cnt - d0, 1);
    check("nul_sw", sw, 16'h6A82);
    check("nul_err", errCode, 0);
    check("nul_ncard", card_q.size() - cb, 0);
    check("nul_ntx", tx_q.size() - tb, 5);

    // P3=00 read: 256 bytes after ACK, then a second ACK with nothing left.
    hdr = 40'h00_B0_00_00_00; tb = tx_q.size(); cb = card_q.size(); d0 = done_cnt;
    start(hdr, 1'b0);
    wait_hdr("r256", hdr, tb);
    rx(8'hB0);
    for (int i = 0; i < 256; i++) rx(8'(i));
    check("r256_ncard", card_q.size() - cb, 256);
    if (card_q.size() - cb == 256) check("r256_last", card_q[cb + 255], 8'hFF);
    check("r256_nodone", done_cnt - d0, 0);
    rx(8'hB0);
    wait_done(d0);
    check("r256_done", done_cnt - d0, 1);
    check("r256_err", errCode, 4);

    // Silent card: ERROR entered 100 cycles after P3 accepted, done two cycles after that.
    wtCycles = 24'd100;
    hdr = 40'h00_B0_00_00_01; tb = tx_q.size(); d0 = done_cnt;
    start(hdr, 1'b0);
    wait_hdr("wt", hdr, tb);
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check("wt_cycles", n, 102);
    check("wt_err", errCode, 1);
    wtCycles = 24'd1000;
    tick();

    // Reset in the middle of the header aborts without done.
    hdr = 40'h00_B0_00_00_01;
    start(hdr, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_txValid", txValid, 0);
    check("rst_mid_busy", busy, 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (5) tick();
    check("rst_mid_nodone", done_cnt - d0, 0);
    check("rst_mid_quiet", txValid, 0);

    // Bad procedure byte.
    hdr = 40'h00_B0_00_00_01; tb = tx_q.size(); d0 = done_cnt;
    start(hdr, 1'b0);
    wait_hdr("bad", hdr, tb);
    rx(8'h55);
    wait_done(d0);
    check("bad_done", done_cnt - d0, 1);
    check("bad_err", errCode, 2);

    // rxError during data, coinciding with rxValid: error wins, byte dropped.
    hdr = 40'h00_B0_00_00_02; tb = tx_q.size(); cb = card_q.size(); d0 = done_cnt;
    start(hdr, 1'b0);
    wait_hdr("rxe", hdr, tb);
    rx(8'hB0); rx(8'h11);
    rxData = 8'h22; rxValid = 1'b1; rxError = 1'b1;
    tick();
    rxValid = 1'b0; rxError = 1'b0;
    wait_done(d0);
    check("rxe_done", done_cnt - d0, 1);
    check("rxe_err", errCode, 3);
    check("rxe_ncard", card_q.size() - cb, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
